id_ibuf: RTL



---
 rtl/id_ibuf.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/id_ibuf.sv
// Instruction buffer between IF and ID: a DEPTH-entry {pc, inst} FIFO that
// keeps the branch delay slot and drops wrong-path fetches on a taken branch.
module id_ibuf #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int SQUASH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [INST_W-1:0]          in_inst,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [PC_W-1:0]            out_pc,
    output logic [INST_W-1:0]          out_inst,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       squashing
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = PC_W + INST_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [2:0] SQ_INIT = 3'(SQUASH);
    localparam bit HAS_SQ = (SQUASH > 0);

    typedef enum logic [1:0] {
        ST_NORMAL,
        ST_WAIT_DS,
        ST_SQUASH
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    sq_cnt_q, sq_cnt_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [EW-1:0] mem_q [DEPTH];

    logic push;
    logic pop;
    logic take_flush;
    logic store;

    // in_ready depends on registered count only; no path from out_ready.
    assign in_ready   = (count_q != FULL);
    assign out_valid  = (count_q != '0);
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    assign take_flush = flush & pop & (state_q == ST_NORMAL);
    assign out_pc     = mem_q[rd_ptr_q][EW-1:INST_W];
    assign out_inst   = mem_q[rd_ptr_q][INST_W-1:0];
    assign occupancy  = count_q;
    assign squashing  = (state_q != ST_NORMAL);

    always_comb begin
        state_d  = state_q;
        sq_cnt_d = sq_cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        store    = 1'b0;
        if (take_flush) begin
            if (count_q >= CW'(2)) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                wr_ptr_d = rd_ptr_q + AW'(2);
                count_d  = CW'(1);
                if (HAS_SQ) begin
                    state_d  = ST_SQUASH;
                    sq_cnt_d = SQ_INIT;
                end
            end else if (push) begin
                // Single entry plus same-cycle push: the push is the slot.
                store    = 1'b1;
                rd_ptr_d = rd_ptr_q + AW'(1);
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (HAS_SQ) begin
                    state_d  = ST_SQUASH;
                    sq_cnt_d = SQ_INIT;
                end
            end else begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                count_d  = '0;
                state_d  = ST_WAIT_DS;
            end
        end else begin
            unique case (state_q)
                ST_NORMAL: store = push;
                ST_WAIT_DS: begin
                    store = push;
                    if (push) begin
                        if (HAS_SQ) begin
                            state_d  = ST_SQUASH;
                            sq_cnt_d = SQ_INIT;
                        end else begin
                            state_d = ST_NORMAL;
                        end
                    end
                end
                ST_SQUASH: begin
                    if (push) begin
                        sq_cnt_d = sq_cnt_q - 3'd1;
                        if (sq_cnt_q <= 3'd1) begin
                            sq_cnt_d = '0;
                            state_d  = ST_NORMAL;
                        end
                    end
                end
                default: state_d = ST_NORMAL;
            endcase
            if (store) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(store) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_NORMAL;
            sq_cnt_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            sq_cnt_q <= sq_cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[wr_ptr_q] <= {in_pc, in_inst};
        end
    end

endmodule
